// File: rtl/etapa_escritura.sv
// Write-back stage: small FIFO of {dir, dato} results draining into an
// 8 x DATA_W register file, with two read ports that bypass pending writes.
module etapa_escritura #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_dato,
    input  logic [ADDR_W-1:0]        in_dir,
    input  logic                     hab_escritura,
    input  logic [ADDR_W-1:0]        rd_dir_a,
    output logic [DATA_W-1:0]        rd_dato_a,
    input  logic [ADDR_W-1:0]        rd_dir_b,
    output logic [DATA_W-1:0]        rd_dato_b,
    output logic [$clog2(DEPTH):0]   pendientes,
    output logic                     vacio
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 2 ** ADDR_W;

    logic [DATA_W-1:0] fifo_dato_q [DEPTH];
    logic [DATA_W-1:0] fifo_dato_d [DEPTH];
    logic [ADDR_W-1:0] fifo_dir_q  [DEPTH];
    logic [ADDR_W-1:0] fifo_dir_d  [DEPTH];
    logic [DATA_W-1:0] regfile_q   [NREG];
    logic [DATA_W-1:0] regfile_d   [NREG];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  byp_idx;
    logic              push, pop;

    // Ready looks only at the registered count: a full FIFO stalls upstream
    // even when the head retires this same cycle.
    assign in_ready   = (cnt_q < CNT_W'(DEPTH));
    assign vacio      = (cnt_q == '0);
    assign pendientes = cnt_q;
    assign push       = in_valid && in_ready;
    assign pop        = hab_escritura && !vacio;

    always_comb begin
        fifo_dato_d = fifo_dato_q;
        fifo_dir_d  = fifo_dir_q;
        regfile_d   = regfile_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        if (push) begin
            fifo_dato_d[wr_ptr_q] = in_dato;
            fifo_dir_d[wr_ptr_q]  = in_dir;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            regfile_d[fifo_dir_q[rd_ptr_q]] = fifo_dato_q[rd_ptr_q];
            rd_ptr_d                        = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_dato_q[i] <= '0;
                fifo_dir_q[i]  <= '0;
            end
            for (int r = 0; r < NREG; r++) begin
                regfile_q[r] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            fifo_dato_q <= fifo_dato_d;
            fifo_dir_q  <= fifo_dir_d;
            regfile_q   <= regfile_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    // Walk pending entries oldest to youngest so the youngest match wins.
    // The head is still counted during its retire cycle, so no stale window.
    always_comb begin
        rd_dato_a = regfile_q[rd_dir_a];
        rd_dato_b = regfile_q[rd_dir_b];
        byp_idx   = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            byp_idx = rd_ptr_q + PTR_W'(i);
            if (CNT_W'(i) < cnt_q) begin
                if (fifo_dir_q[byp_idx] == rd_dir_a) rd_dato_a = fifo_dato_q[byp_idx];
                if (fifo_dir_q[byp_idx] == rd_dir_b) rd_dato_b = fifo_dato_q[byp_idx];
            end
        end
    end

endmodule

// File: tb/tb_etapa_escritura.sv
// Self-checking bench for etapa_escritura: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_etapa_escritura;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [13:0] in_dato = '0;
    logic [2:0]  in_dir = '0;
    logic        hab_escritura = 1'b0;
    logic [2:0]  rd_dir_a = '0;
    logic [13:0] rd_dato_a;
    logic [2:0]  rd_dir_b = '0;
    logic [13:0] rd_dato_b;
    logic [1:0]  pendientes;
    logic        vacio;

    etapa_escritura #(.DATA_W(14), .ADDR_W(3), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dato(in_dato), .in_dir(in_dir),
        .hab_escritura(hab_escritura),
        .rd_dir_a(rd_dir_a), .rd_dato_a(rd_dato_a),
        .rd_dir_b(rd_dir_b), .rd_dato_b(rd_dato_b),
        .pendientes(pendientes), .vacio(vacio)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  dir;
        logic [13:0] dato;
    } ent_t;

    ent_t        q[$];
    logic [13:0] rf[8];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [13:0] mread(input logic [2:0] a);
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].dir == a) return q[i].dato;
        return rf[a];
    endfunction

    task automatic model_clear();
        q.delete();
        for (int r = 0; r < 8; r++) rf[r] = '0;
    endtask

    // One clock: drive at negedge, check just after, advance model at posedge.
    task automatic step(input bit v, input logic [2:0] dir, input logic [13:0] dato,
                        input bit hab, input logic [2:0] ra, input logic [2:0] rb);
        bit acc, ret;
        ent_t e;
        @(negedge clk);
        in_valid = v; in_dir = dir; in_dato = dato; hab_escritura = hab;
        rd_dir_a = ra; rd_dir_b = rb;
        #1;
        chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        chk("pendientes", 32'(pendientes), 32'(q.size()));
        chk("vacio", 32'(vacio), 32'(q.size() == 0));
        chk("rd_dato_a", 32'(rd_dato_a), 32'(mread(ra)));
        chk("rd_dato_b", 32'(rd_dato_b), 32'(mread(rb)));
        @(posedge clk);
        acc = v && (q.size() < DEPTH);
        ret = hab && (q.size() > 0);
        if (ret) begin
            e = q.pop_front();
            rf[e.dir] = e.dato;
        end
        if (acc) begin
            e.dir = dir; e.dato = dato;
            q.push_back(e);
        end
    endtask

    // Idle read of one address against a fixed expected value.
    task automatic peek(input string tag, input logic [2:0] a, input logic [13:0] exp);
        @(negedge clk);
        in_valid = 1'b0; hab_escritura = 1'b0; rd_dir_a = a;
        #1;
        chk(tag, 32'(rd_dato_a), 32'(exp));
    endtask

    initial begin
        model_clear();
        @(negedge clk); @(negedge clk);
        chk("rst_pend", 32'(pendientes), 32'd0);
        chk("rst_vacio", 32'(vacio), 32'd1);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_rd_b", 32'(rd_dato_b), 32'd0);
        rst_n = 1'b1;

        // basic write, visible via bypass the cycle after acceptance
        step(1, 3'd3, 14'h1A5, 1, 3'd3, 3'd3);
        step(0, 3'd0, 14'h0,   1, 3'd3, 3'd3);
        step(0, 3'd0, 14'h0,   1, 3'd3, 3'd3);
        peek("basic_rf3", 3'd3, 14'h1A5);

        // back-pressure: third push refused while full
        step(1, 3'd1, 14'h0011, 0, 3'd1, 3'd2);
        step(1, 3'd2, 14'h0022, 0, 3'd1, 3'd2);
        step(1, 3'd4, 14'h3333, 0, 3'd1, 3'd4);
        for (int k = 0; k < 3; k++) step(0, 3'd0, 14'h0, 1, 3'd1, 3'd2);
        peek("bp_rf1", 3'd1, 14'h0011);
        peek("bp_rf2", 3'd2, 14'h0022);
        peek("bp_rf4", 3'd4, 14'h0000);

        // same-address ordering, youngest wins every cycle
        step(1, 3'd5, 14'h3FFF, 0, 3'd5, 3'd5);
        step(1, 3'd5, 14'h0001, 0, 3'd5, 3'd5);
        for (int k = 0; k < 3; k++) step(0, 3'd0, 14'h0, 1, 3'd5, 3'd5);
        peek("same_rf5", 3'd5, 14'h0001);

        // empty retire is a no-op
        for (int k = 0; k < 5; k++) step(0, 3'd0, 14'h0, 1, 3'(k), 3'(k + 3));

        // push/pop every cycle, pointers wrap several times
        for (int i = 0; i < 10; i++) step(1, 3'(i % 8), 14'(i), 1, 3'(i % 8), 3'((i + 7) % 8));
        step(0, 3'd0, 14'h0, 1, 3'd0, 3'd1);
        step(0, 3'd0, 14'h0, 1, 3'd0, 3'd1);
        peek("wrap_rf0", 3'd0, 14'd8);
        peek("wrap_rf1", 3'd1, 14'd9);
        for (int r = 2; r < 8; r++) peek("wrap_rf", 3'(r), 14'(r));

        // reset mid-stream with two entries queued
        step(1, 3'd6, 14'h0AAA, 0, 3'd6, 3'd7);
        step(1, 3'd7, 14'h0BBB, 0, 3'd6, 3'd7);
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b1; hab_escritura = 1'b1;
        #1;
        chk("mrst_pend", 32'(pendientes), 32'd0);
        chk("mrst_vacio", 32'(vacio), 32'd1);
        chk("mrst_ready", 32'(in_ready), 32'd1);
        for (int r = 0; r < 8; r++) begin
            rd_dir_a = 3'(r);
            #1;
            chk("mrst_rd", 32'(rd_dato_a), 32'd0);
        end
        model_clear();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) step(0, 3'd0, 14'h0, 1, 3'd6, 3'd7);

        // random traffic
        for (int k = 0; k < 400; k++)
            step(($urandom_range(0, 3) != 0), 3'($urandom), 14'($urandom),
                 ($urandom_range(0, 2) != 0), 3'($urandom), 3'($urandom));
        for (int k = 0; k < 3; k++) step(0, 3'd0, 14'h0, 1, 3'($urandom), 3'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/etapa_escritura.md
Name: etapa_escritura

Overview:
- Write-back stage directly downstream of the 14-bit data mover.
- Accepts the mover's 14-bit result plus a destination register address over a valid/ready handshake, and queues it in a small FIFO.
- Retires one queued write per enabled cycle into an 8 x 14-bit register file.
- Provides two combinational read ports with bypass from pending (not yet retired) writes, so downstream reads always see the newest value.

Parameters:
- DATA_W, 14, data width; matches mover output.
- ADDR_W, 3, register address width; the register file has 2**ADDR_W entries.
- DEPTH, 2, FIFO depth in entries; power of two, minimum 2.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream (mover) result valid.
- in_ready  output  1  stage can accept an entry this cycle.
- in_dato  input  DATA_W  result value from mover.
- in_dir  input  ADDR_W  destination register.
- hab_escritura  input  1  permits the FIFO head to retire into the register file this cycle.
- rd_dir_a  input  ADDR_W  read port A address.
- rd_dato_a  output  DATA_W  read port A data.
- rd_dir_b  input  ADDR_W  read port B address.
- rd_dato_b  output  DATA_W  read port B data.
- pendientes  output  clog2(DEPTH)+1  number of queued, unretired entries.
- vacio  output  1  pendientes == 0.

Behaviour:
- Reset (rst_n=0, asynchronous): all register file entries = 0, FIFO pointers = 0, pendientes = 0, vacio = 1, in_ready = 1. Read ports then return 0.
- Reset asserted mid-operation discards all queued entries immediately; nothing retires after reset.
- Accept: in_valid && in_ready at a rising edge pushes {in_dir, in_dato} at the tail. in_ready = (pendientes < DEPTH), combinational from the registered count only, with no dependency on in_valid.
- When full, in_ready = 0 even if a retire happens in the same cycle. This is deliberate: there is no ready-through-drain path.
- Retire: hab_escritura && !vacio at a rising edge writes the head data into regfile[head dir] and pops the head.
- Empty with hab_escritura = 1: no-op, no underflow.
- Push and pop in the same edge: pendientes unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Latency with hab_escritura held at 1:
  - entry accepted at edge N is head during cycle N+1;
  - it retires at edge N+1;
  - it is visible from the register file from cycle N+2.
- Bypass: each read port returns the data of the youngest valid FIFO entry whose dir equals the read address; if none matches, it returns regfile[addr].
- Bypass includes the entry retiring in the current cycle, so reads never see stale data across the retire edge.
- Bypass does not include the in_dato being accepted this cycle; that value becomes visible the cycle after acceptance.
- Multiple pending writes to the same address retire in order; the last one wins, both in the register file and in bypass.
- Read ports are purely combinational. Ports A and B are independent and may read the same address.
- No register is hardwired; address 0 is writable.
- Arithmetic: pendientes increments on push only, decrements on pop only; it never exceeds DEPTH and never goes below 0.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 2 entries queued -> pendientes=0, vacio=1, in_ready=1, rd_dato_a for addresses 0..7 = 0 immediately; release, no writes appear.
- Basic write: hab_escritura=1, push dir=3 dato=14'h1A5 at edge N -> rd_dato_a(dir 3)=14'h1A5 from cycle N+1 (via bypass) and remains 14'h1A5 after retire; pendientes returns to 0 at N+2.
- Back-pressure: hab_escritura=0, push dir=1 dato=14'h0011, then dir=2 dato=14'h0022 -> pendientes=2, in_ready=0; a third push with in_valid=1 is not accepted. Set hab_escritura=1 -> retires in order over 2 cycles, regfile[1]=14'h0011, regfile[2]=14'h0022.
- Same-address ordering: hab_escritura=0, push dir=5 dato=14'h3FFF, then dir=5 dato=14'h0001 -> rd_dato_b(dir 5)=14'h0001 via bypass. Enable writes -> after both retire, regfile[5]=14'h0001, with no glitch to 14'h3FFF on the read port in any cycle.
- Simultaneous push/pop: with 1 entry pending and hab_escritura=1, push a new entry -> pendientes stays 1; pointer wrap is exercised over 10 consecutive push/pop cycles with data 0..9 to dirs 0..7,0,1 -> final regfile[0]=8, regfile[1]=9, regfile[2..7]=2..7.
- Empty retire: hab_escritura=1 with vacio=1 for 5 cycles -> no register changes, pendientes stays 0.
